aoi22_cell_sweeper: RTL and testbench
=====================================

Name: aoi22_cell_sweeper

Overview:
- Sequencer that exercises one transistor-level AOI22 cell instance in-circuit.
- Steps the cell inputs through all 16 input combinations, holds each for a programmable settle time, samples Y and compares it against the expected value ~((A1&A2)|(B1&B2)).
- Reports a mismatch count, the first failing vector and a pass flag.
- Sits beside the cell library as the standard bring-up and regression harness for library cells; it also serves as a template for sweepers on other cells.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before Y is sampled (0..255).
- LOOPS, 1, number of full 16-vector sweeps per START (1..255).
- ERRCNT_W, 5, width of the saturating mismatch counter.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to begin a run.
- Y  in  1  output of the cell under sweep.
- A1  out  1  cell input, vector bit 3.
- A2  out  1  cell input, vector bit 2.
- B1  out  1  cell input, vector bit 1.
- B2  out  1  cell input, vector bit 0.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished; held until next accepted START or RST.
- PASS  out  1  DONE and ERR_COUNT==0.
- ERR_COUNT  out  ERRCNT_W  saturating mismatch count for the run.
- FAIL_VALID  out  1  at least one mismatch in this run.
- FAIL_VEC  out  4  {A1,A2,B1,B2} of the first mismatch; 0 if none.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is CLK and the reset port is RST.
- Reset: when RST is high at a rising edge, the block goes to IDLE and clears its state. After that edge all outputs read 0: A1, A2, B1, B2, BUSY, DONE, PASS, ERR_COUNT, FAIL_VALID, FAIL_VEC. RST overrides START. RST mid-run aborts the run immediately with no DONE.
- States: IDLE, HOLD, SAMPLE, FINISH.
- IDLE:
  - START=1 -> HOLD on the next edge.
  - On that edge: vector index v=0, loop counter=0, ERR_COUNT/FAIL_VALID/FAIL_VEC/DONE cleared, BUSY=1.
- HOLD:
  - {A1,A2,B1,B2}=v is registered and driven.
  - Stays in HOLD for SETTLE_CYCLES cycles, then -> SAMPLE.
  - If SETTLE_CYCLES=0, HOLD lasts 1 cycle.
- SAMPLE (1 cycle):
  - Y is compared to expected E = ~((v[3]&v[2])|(v[1]&v[0])).
  - Comparison is case-inequality, so X/Z on Y counts as a mismatch.
  - On a mismatch: ERR_COUNT increments, saturating at 2^ERRCNT_W-1.
  - On the first mismatch of the run: FAIL_VEC=v and FAIL_VALID=1. Later mismatches do not change either.
  - Then: if v<15, v+1 and go to HOLD. If v==15 and loops remain, v wraps to 0 and go to HOLD. Otherwise -> FINISH.
- Vector timing: each vector is driven for max(SETTLE_CYCLES,1)+1 cycles. With default SETTLE_CYCLES=2, one sweep is 16×3 = 48 cycles.
- FINISH:
  - BUSY=0, DONE=1, PASS=(ERR_COUNT==0).
  - A1, A2, B1, B2 return to 0.
  - State is treated as IDLE for START purposes.
- START handling:
  - START while BUSY is ignored, with no restart and no effect on the counters.
  - START while DONE=1 starts a new run and clears DONE, PASS and the results on the accepting edge.
- Output register rules:
  - A1, A2, B1, B2 change only on clock edges and never glitch between vectors.
  - ERR_COUNT and FAIL_* are stable while DONE=1.

Test Plan:
- Ideal AOI22 model, defaults: START pulse -> BUSY=1 on the next cycle; vectors 0..15 each held 3 cycles; DONE=1 and PASS=1 exactly 48 cycles after BUSY rises; ERR_COUNT=0, FAIL_VALID=0, FAIL_VEC=0.
- Y stuck-at-0 -> DONE with ERR_COUNT=9, FAIL_VALID=1, FAIL_VEC=4'b0000, PASS=0.
- Y stuck-at-1 -> ERR_COUNT=7, FAIL_VEC=4'b0011; same run with LOOPS=2 -> ERR_COUNT=14 and DONE after 96 cycles.
- Y wired as NAND(A1,A2) -> ERR_COUNT=3, FAIL_VEC=4'b0011. With ERRCNT_W=3 and Y stuck-at-0 -> ERR_COUNT saturates at 7.
- RST asserted during vector 6, then START -> all outputs 0 the cycle after RST; the new run restarts from vector 0 with cleared counters. START pulses during BUSY have no effect, and total run length stays 48 cycles.
- SETTLE_CYCLES=0 with the ideal model -> each vector held 2 cycles; DONE 32 cycles after BUSY rises; Y driven to X on vector 9 only -> ERR_COUNT=1, FAIL_VEC=4'b1001.

Source files
------------

// File: rtl/aoi22_cell_sweeper.sv
// In-circuit sweeper for one AOI22 cell: walks all 16 input vectors, samples Y
// after a settle time, and reports mismatch count, first failing vector and pass.
module aoi22_cell_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned LOOPS         = 1,
   parameter int unsigned ERRCNT_W      = 5
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic                Y,
   output logic                A1,
   output logic                A2,
   output logic                B1,
   output logic                B2,
   output logic                BUSY,
   output logic                DONE,
   output logic                PASS,
   output logic [ERRCNT_W-1:0] ERR_COUNT,
   output logic                FAIL_VALID,
   output logic [3:0]          FAIL_VEC
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      SAMPLE,
      FINISH
   } stateT;

   // A zero settle time still needs one HOLD cycle so Y sees the new vector.
   localparam int unsigned HOLD_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
   localparam int unsigned LOOP_LAST = (LOOPS == 0) ? 0 : LOOPS - 1;

   stateT                state;
   logic [3:0]           vecIdx;
   logic [7:0]           holdCnt;
   logic [7:0]           loopCnt;
   logic                 expected;
   logic                 mismatch;
   logic [ERRCNT_W-1:0]  errNext;

   always_comb begin
      expected = ~((vecIdx[3] & vecIdx[2]) | (vecIdx[1] & vecIdx[0]));
      // Case inequality so an undriven or unknown Y is reported as a failure.
      mismatch = (Y !== expected);
      errNext  = ERR_COUNT;
      if (mismatch && (ERR_COUNT != '1)) begin
         errNext = ERR_COUNT + ERRCNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state             <= IDLE;
         vecIdx            <= '0;
         holdCnt           <= '0;
         loopCnt           <= '0;
         {A1, A2, B1, B2}  <= '0;
         BUSY              <= 1'b0;
         DONE              <= 1'b0;
         PASS              <= 1'b0;
         ERR_COUNT         <= '0;
         FAIL_VALID        <= 1'b0;
         FAIL_VEC          <= '0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if (START) begin
                  state            <= HOLD;
                  vecIdx           <= '0;
                  holdCnt          <= '0;
                  loopCnt          <= '0;
                  {A1, A2, B1, B2} <= '0;
                  BUSY             <= 1'b1;
                  DONE             <= 1'b0;
                  PASS             <= 1'b0;
                  ERR_COUNT        <= '0;
                  FAIL_VALID       <= 1'b0;
                  FAIL_VEC         <= '0;
               end
            end

            HOLD: begin
               if (holdCnt == 8'(HOLD_LAST)) begin
                  state <= SAMPLE;
               end else begin
                  holdCnt <= holdCnt + 8'd1;
               end
            end

            SAMPLE: begin
               ERR_COUNT <= errNext;
               if (mismatch && !FAIL_VALID) begin
                  FAIL_VALID <= 1'b1;
                  FAIL_VEC   <= vecIdx;
               end
               holdCnt <= '0;
               if (vecIdx != 4'd15) begin
                  state            <= HOLD;
                  vecIdx           <= vecIdx + 4'd1;
                  {A1, A2, B1, B2} <= vecIdx + 4'd1;
               end else if (loopCnt != 8'(LOOP_LAST)) begin
                  state            <= HOLD;
                  loopCnt          <= loopCnt + 8'd1;
                  vecIdx           <= '0;
                  {A1, A2, B1, B2} <= '0;
               end else begin
                  state            <= FINISH;
                  {A1, A2, B1, B2} <= '0;
                  BUSY             <= 1'b0;
                  DONE             <= 1'b1;
                  PASS             <= (errNext == '0);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aoi22_cell_sweeper.sv
// Directed bench for aoi22_cell_sweeper: four instances with different parameters,
// each driven by a behavioural cell model selected per scenario.
module tb_aoi22_cell_sweeper;

   logic       CLK;
   logic       RST;
   logic       startI [4];
   logic       yI     [4];
   int         ymode  [4];
   logic [3:0] vecO   [4];
   logic       busyO  [4];
   logic       doneO  [4];
   logic       passO  [4];
   logic       fvO    [4];
   logic [3:0] fvecO  [4];
   logic [4:0] errO   [4];

   int checks;
   int failures;

   // Cell models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 NAND(A1,A2), 4 ideal with X on vector 9.
   function automatic logic yModel(input int mode, input logic [3:0] v);
      logic ideal;
      ideal = ~((v[3] & v[2]) | (v[1] & v[0]));
      case (mode)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return ~(v[3] & v[2]);
         4:       return (v == 4'd9) ? 1'bx : ideal;
         default: return ideal;
      endcase
   endfunction

   // Instance 0: defaults; 1: LOOPS=2; 2: ERRCNT_W=3; 3: SETTLE_CYCLES=0.
   for (genvar g = 0; g < 4; g++) begin : gDut
      localparam int unsigned SC = (g == 3) ? 0 : 2;
      localparam int unsigned LP = (g == 1) ? 2 : 1;
      localparam int unsigned EW = (g == 2) ? 3 : 5;
      logic          a1, a2, b1, b2;
      logic [EW-1:0] errLocal;

      aoi22_cell_sweeper #(
         .SETTLE_CYCLES(SC),
         .LOOPS(LP),
         .ERRCNT_W(EW)
      ) dut (
         .CLK(CLK),
         .RST(RST),
         .START(startI[g]),
         .Y(yI[g]),
         .A1(a1),
         .A2(a2),
         .B1(b1),
         .B2(b2),
         .BUSY(busyO[g]),
         .DONE(doneO[g]),
         .PASS(passO[g]),
         .ERR_COUNT(errLocal),
         .FAIL_VALID(fvO[g]),
         .FAIL_VEC(fvecO[g])
      );

      assign vecO[g] = {a1, a2, b1, b2};
      assign errO[g] = 5'(errLocal);
      assign yI[g]   = yModel(ymode[g], {a1, a2, b1, b2});
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Pulse START on one instance and run until DONE; optionally check the vector
   // sequence (hold = cycles per vector) and poke START while busy.
   task automatic runSweep(input int idx, input int limit, input int hold, input bit poke,
                           output int cycles);
      startI[idx] = 1'b1;
      tick();
      startI[idx] = 1'b0;
      checks++;
      if (busyO[idx] !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_start[%0d]: got %b want 1", idx, busyO[idx]);
      end
      cycles = 0;
      while (!doneO[idx] && cycles < limit) begin
         if (hold > 0) begin
            checks++;
            if (vecO[idx] !== 4'(cycles / hold)) begin
               failures++;
               $display("FAIL vector_seq[%0d] cycle %0d: got %0d want %0d",
                        idx, cycles, vecO[idx], cycles / hold);
            end
         end
         startI[idx] = poke && (cycles == 5 || cycles == 20 || cycles == 40);
         tick();
         startI[idx] = 1'b0;
         cycles++;
      end
      checks++;
      if (doneO[idx] !== 1'b1) begin
         failures++;
         $display("FAIL done_timeout[%0d]: DONE not seen within %0d cycles", idx, limit);
      end
   endtask

   task automatic checkResult(input string name, input int idx, input int cycles, input int wantCycles,
                              input logic [4:0] wantErr, input logic [3:0] wantVec,
                              input logic wantPass);
      checks++;
      if (cycles !== wantCycles) begin
         failures++;
         $display("FAIL %s run_length: got %0d want %0d", name, cycles, wantCycles);
      end
      checks++;
      if (errO[idx] !== wantErr) begin
         failures++;
         $display("FAIL %s err_count: got %0d want %0d", name, errO[idx], wantErr);
      end
      checks++;
      if (fvecO[idx] !== wantVec) begin
         failures++;
         $display("FAIL %s fail_vec: got %b want %b", name, fvecO[idx], wantVec);
      end
      checks++;
      if (fvO[idx] !== (wantErr != 0)) begin
         failures++;
         $display("FAIL %s fail_valid: got %b want %b", name, fvO[idx], wantErr != 0);
      end
      checks++;
      if (passO[idx] !== wantPass || busyO[idx] !== 1'b0 || vecO[idx] !== 4'd0) begin
         failures++;
         $display("FAIL %s pass_busy_vec: got pass=%b busy=%b vec=%b want pass=%b busy=0 vec=0000",
                  name, passO[idx], busyO[idx], vecO[idx], wantPass);
      end
   endtask

   task automatic checkAllZero(input string name);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({vecO[i], busyO[i], doneO[i], passO[i], fvO[i], fvecO[i], errO[i]} !== '0) begin
            failures++;
            $display("FAIL %s[%0d]: got vec=%b busy=%b done=%b pass=%b fv=%b fvec=%b err=%0d want all 0",
                     name, i, vecO[i], busyO[i], doneO[i], passO[i], fvO[i], fvecO[i], errO[i]);
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      for (int i = 0; i < 4; i++) startI[i] = 1'b1;
      tick();
      tick();
      checkAllZero("reset_state");
      for (int i = 0; i < 4; i++) startI[i] = 1'b0;
      RST = 1'b0;
      tick();
      checkAllZero("idle_after_reset");
   endtask

   task automatic test_ideal();
      int cycles;
      ymode[0] = 0;
      runSweep(0, 200, 3, 1'b0, cycles);
      checkResult("ideal", 0, cycles, 48, 5'd0, 4'b0000, 1'b1);
      tick();
      tick();
      checkResult("ideal_hold", 0, 48, 48, 5'd0, 4'b0000, 1'b1);
   endtask

   task automatic test_stuck0();
      int cycles;
      ymode[0] = 1;
      runSweep(0, 200, 3, 1'b0, cycles);
      checkResult("stuck0", 0, cycles, 48, 5'd9, 4'b0000, 1'b0);
   endtask

   task automatic test_nand();
      int cycles;
      ymode[0] = 3;
      runSweep(0, 200, 3, 1'b0, cycles);
      checkResult("nand", 0, cycles, 48, 5'd3, 4'b0011, 1'b0);
   endtask

   task automatic test_stuck1_loops();
      int cycles;
      ymode[1] = 2;
      runSweep(1, 300, 0, 1'b0, cycles);
      checkResult("stuck1_loops2", 1, cycles, 96, 5'd14, 4'b0011, 1'b0);
   endtask

   task automatic test_saturate();
      int cycles;
      ymode[2] = 1;
      runSweep(2, 200, 3, 1'b0, cycles);
      checkResult("saturate_w3", 2, cycles, 48, 5'd7, 4'b0000, 1'b0);
   endtask

   task automatic test_reset_midrun();
      int cycles;
      int waitCnt;
      ymode[0] = 0;
      startI[0] = 1'b1;
      tick();
      startI[0] = 1'b0;
      waitCnt = 0;
      while (vecO[0] !== 4'd6 && waitCnt < 100) begin
         tick();
         waitCnt++;
      end
      checks++;
      if (vecO[0] !== 4'd6) begin
         failures++;
         $display("FAIL reach_vector6: got %0d want 6", vecO[0]);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checkAllZero("abort_reset");
      tick();
      runSweep(0, 200, 3, 1'b1, cycles);
      checkResult("restart_with_pokes", 0, cycles, 48, 5'd0, 4'b0000, 1'b1);
   endtask

   task automatic test_settle0();
      int cycles;
      ymode[3] = 0;
      runSweep(3, 200, 2, 1'b0, cycles);
      checkResult("settle0_ideal", 3, cycles, 32, 5'd0, 4'b0000, 1'b1);
      ymode[3] = 4;
      runSweep(3, 200, 2, 1'b0, cycles);
      checkResult("settle0_x_vec9", 3, cycles, 32, 5'd1, 4'b1001, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      RST      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         startI[i] = 1'b0;
         ymode[i]  = 0;
      end
      test_reset();
      test_ideal();
      test_stuck0();
      test_nand();
      test_stuck1_loops();
      test_saturate();
      test_reset_midrun();
      test_settle0();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
